// File: rtl/zz_pkg.sv
// Shared constants for the zigzag reorder buffer: block geometry and the
// 8x8 JPEG zigzag index -> raster address table.
package zz_pkg;

  localparam int BLK_SIZE = 64;
  localparam int LAST_IDX = 63;

  localparam logic [5:0] ZZ_TABLE [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/zigzag_rom.sv
// Combinational zigzag map: output-order index -> raster address in the block.
module zigzag_rom
  import zz_pkg::*;
(
  input  logic [5:0] idx_i,
  output logic [5:0] addr_o
);

  assign addr_o = ZZ_TABLE[idx_i];

endmodule

// File: rtl/zz_buf_ctrl.sv
// Ping-pong controller: raster samples written to two external bank RAMs, read
// back in zigzag order. Optional blk_cnt output under ZZ_BUF_CTRL_BLKCNT_EN.
module zz_buf_ctrl
  import zz_pkg::*;
#(
  parameter int RAMADDR_W = 6,
  parameter int RAMDATA_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RAMDATA_W-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [RAMDATA_W-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [RAMDATA_W-1:0] ram_d,
  output logic [RAMADDR_W-1:0] ram_waddr,
  output logic                 ram_we0,
  output logic                 ram_we1,
  output logic [RAMADDR_W-1:0] ram_raddr,
  input  logic [RAMDATA_W-1:0] ram_q0,
  input  logic [RAMDATA_W-1:0] ram_q1
`ifdef ZZ_BUF_CTRL_BLKCNT_EN
  ,
  output logic [15:0]          blk_cnt
`endif
);

  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [RAMADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [RAMADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]           full_q, full_d;
  logic                 in_xfer, out_xfer, wr_last, rd_last;
  logic [5:0]           zz_addr;

  assign in_ready  = ~full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign wr_last   = (wr_ptr_q == RAMADDR_W'(LAST_IDX));
  assign rd_last   = (rd_ptr_q == RAMADDR_W'(LAST_IDX));

  assign ram_d     = in_data;
  assign ram_waddr = wr_ptr_q;
  assign ram_we0   = in_xfer & ~wr_bank_q;
  assign ram_we1   = in_xfer & wr_bank_q;

  // Read address looks one sample ahead so the registered RAM address lines
  // up with rd_ptr after the edge.
  zigzag_rom u_zz (
    .idx_i  (6'(rd_ptr_d)),
    .addr_o (zz_addr)
  );
  assign ram_raddr = RAMADDR_W'(zz_addr);

  assign out_data = rd_bank_q ? ram_q1 : ram_q0;
  assign out_last = out_valid & rd_last;

  // Set and clear can coincide but always hit different banks.
  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    full_d    = full_q;
    if (in_xfer) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    if (out_xfer) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if (rd_last) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      full_q    <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      full_q    <= full_d;
    end
  end

`ifdef ZZ_BUF_CTRL_BLKCNT_EN
  logic [15:0] blk_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       blk_cnt_q <= '0;
    else if (out_xfer && rd_last)  blk_cnt_q <= blk_cnt_q + 16'd1;
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule
